imem_responder: RTL
===================

Name: imem_responder

Overview:
- Instruction-memory responder: the memory-side end of the fetch interface driven by the fetch unit.
- Accepts fetch requests on a valid/ready request channel and reads a word-addressed instruction RAM through a fixed-latency read pipeline.
- Returns instruction words on a valid/ready response channel, buffered in a response FIFO so the core can stall without losing data.
- A separate load port fills the RAM at boot or from a debug host.

Parameters:
DEPTH, 256, number of 32-bit instruction words (power of two, 16..4096)
LATENCY, 1, read pipeline stages between request accept and FIFO write (1..4)
FIFO_DEPTH, 4, response FIFO entries; also the maximum number of outstanding requests (power of two, >= LATENCY)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  fetch request valid
req_ready  out  1  responder can accept a request
req_addr  in  32  byte address of the requested instruction
rsp_valid  out  1  response available at FIFO head
rsp_ready  in  1  consumer accepts the response
rsp_data  out  32  instruction word; 0 when rsp_err=1
rsp_err  out  1  request was misaligned or out of range
load_en  in  1  write one word into the RAM
load_addr  in  $clog2(DEPTH)  word index for the load
load_data  in  32  word to write

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0; req_ready=0 while reset is asserted, then 1 on the first cycle after release.
  - Pipeline valid bits, FIFO pointers and outstanding count cleared.
  - In-flight and buffered responses are discarded; RAM contents are not reset.
- Request accept: req_valid && req_ready at a rising edge.
- req_ready = (outstanding < FIFO_DEPTH). It is registered-path only, with no combinational dependence on req_valid or rsp_ready.
- outstanding = accepted requests not yet popped from the FIFO:
  - +1 on accept, -1 on pop (rsp_valid && rsp_ready).
  - Both in the same cycle leaves it unchanged.
  - Width $clog2(FIFO_DEPTH)+1.
- Address decode:
  - Word index = req_addr[$clog2(DEPTH)+1:2].
  - err = (req_addr[1:0] != 0) || (req_addr >= DEPTH*4).
  - On err, RAM data is ignored and a response with rsp_data=0, rsp_err=1 is returned.
- Latency:
  - A request accepted at edge N is written into the FIFO at edge N+LATENCY.
  - If the FIFO was empty, rsp_valid rises in the cycle after edge N+LATENCY.
  - Minimum accept-to-rsp_valid = LATENCY cycles.
- Ordering: responses are returned strictly in request order. There are no drops and no duplicates.
- Throughput: one request per cycle sustained while rsp_ready=1; back-to-back accepts are allowed.
- Backpressure:
  - The FIFO never overflows; the credit rule guarantees a slot for every in-flight request.
  - rsp_data and rsp_err must hold stable while rsp_valid=1 && rsp_ready=0.
- FIFO:
  - Full when the count equals FIFO_DEPTH.
  - Simultaneous push and pop when full or empty is legal.
  - Pointers wrap modulo FIFO_DEPTH.
  - Output is taken directly from the head entry (no bubble after pop).
- Load port:
  - A load writes at the edge.
  - When a load and a request read target the same word in the same cycle, the read returns the OLD data (read-before-write).
  - Loads are always accepted; no ready signal.
- Reset mid-operation: an asynchronous assert clears all state immediately. After release no stale response appears.

Decomposition:
- Shared package imem_pkg holds:
  - constant XLEN=32;
  - constant NOP_WORD=32'h0000_0013 (documentation only; the error data is 0);
  - typedef imem_rsp_t {data[31:0], err}.
- One sub-module is natural: sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count). It stores imem_rsp_t entries.
- The RAM array and the read pipeline stay in imem_responder.

Test Plan:
1. Reset, load words 0..3 = 32'hA0..A3, request addrs 0,4,8,12 back-to-back with rsp_ready=1 and LATENCY=1 -> rsp_data A0,A1,A2,A3 on 4 consecutive cycles, first one cycle after the first accept, rsp_err=0.
2. Hold rsp_ready=0 and issue 6 requests with FIFO_DEPTH=4 -> exactly 4 accepted, then req_ready=0. Raise rsp_ready -> 4 responses in order, then req_ready=1 and the remaining 2 are accepted.
3. Request addr 32'h2 and addr 32'h400 (DEPTH=256) -> two responses, rsp_err=1, rsp_data=0. An adjacent valid request at addr 0 still returns word 0 correctly and in order.
4. Same-cycle load of word 5 = 32'hDEAD and read of addr 20 (word 5, old 32'h1111) -> response 32'h1111. A second read of addr 20 -> 32'hDEAD.
5. Assert rst_n low with 3 requests in flight, release, then request addr 0 -> exactly one response (word 0) and no stale data.
6. LATENCY=3, FIFO_DEPTH=4, random rsp_ready toggling over 1000 requests -> scoreboard matches in order, rsp_data stable under stall, outstanding never exceeds 4.

Source files
------------

// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory responder.
//   XLEN       : instruction word width
//   NOP_WORD   : canonical RISC-V NOP (addi x0,x0,0), kept for reference;
//                error responses carry 0, not this value
//   imem_rsp_t : one response entry, instruction word plus error flag
// ---------------------------------------------------------------------------
package imem_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            err;
  } imem_rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO holding response entries. The head entry drives
// pop_data directly, so a pop is followed by the next entry without a bubble.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears pointers/count)
//   push        : write push_data at the rising edge (ignored when full
//                 unless a pop happens in the same cycle)
//   pop         : drop the head entry (ignored when empty)
//   pop_data    : current head entry
//   full, empty : occupancy flags
//   count       : number of stored entries
// ---------------------------------------------------------------------------
module sync_fifo
  import imem_pkg::*;
#(
  parameter int WIDTH = $bits(imem_rsp_t),
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer wrap is explicit so non-power-of-two depths would also work.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
// Memory-side end of the instruction fetch interface. Requests are accepted
// on a valid/ready channel, the word-addressed RAM is read through a
// LATENCY-stage pipeline and results are queued in a response FIFO.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake
//   req_addr             : byte address of the instruction
//   rsp_valid/rsp_ready  : response handshake (FIFO head)
//   rsp_data, rsp_err    : instruction word (0 on error), error flag
//   load_en/addr/data    : RAM fill port, one word per cycle, always taken
// ---------------------------------------------------------------------------
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  logic [XLEN-1:0] ram_q [DEPTH];

  logic            ready_en_q;
  logic [OW-1:0]   outstanding_q, outstanding_d;

  imem_rsp_t       pipe_q [LATENCY];
  imem_rsp_t       pipe_d [LATENCY];
  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;

  logic            accept, pop, req_err;
  logic [AW-1:0]   req_idx;
  imem_rsp_t       fifo_head;
  logic            fifo_full, fifo_empty;
  logic [OW-1:0]   fifo_count;
  logic            unused_fifo_status;

  // req_ready only looks at flops: the credit counter limits in-flight plus
  // buffered responses to the FIFO size, so the FIFO can never overflow.
  // ready_en_q keeps it low while reset is asserted.
  assign req_ready = ready_en_q && (outstanding_q < OW'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = fifo_head.data;
  assign rsp_err   = fifo_head.err;

  assign req_idx = req_addr[AW+1:2];
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_LIMIT);

  assign unused_fifo_status = ^{fifo_full, fifo_count};

  always_comb begin
    outstanding_d = outstanding_q + OW'(accept) - OW'(pop);
  end

  // Stage 0 samples the RAM at the accept edge; the load write lands on the
  // same edge, so a same-word read sees the old contents.
  always_comb begin
    pipe_d[0].data = req_err ? '0 : ram_q[req_idx];
    pipe_d[0].err  = req_err;
    pipe_vld_d     = '0;
    pipe_vld_d[0]  = accept;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i]     = pipe_q[i-1];
      pipe_vld_d[i] = pipe_vld_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q    <= 1'b0;
      outstanding_q <= '0;
      pipe_vld_q    <= '0;
    end else begin
      ready_en_q    <= 1'b1;
      outstanding_q <= outstanding_d;
      pipe_vld_q    <= pipe_vld_d;
    end
  end

  // Data path and RAM carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LATENCY; i++) begin
      pipe_q[i] <= pipe_d[i];
    end
    if (load_en) begin
      ram_q[load_addr] <= load_data;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(imem_rsp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_vld_q[LATENCY-1]),
    .push_data (pipe_q[LATENCY-1]),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
